// File: rtl/c_wl_prog_ctrl.sv
// Wordline programming sequencer: fetch, setup, pulse and hold per crossbar row.
// Optional read-back verify with retry is enabled by C_WL_PROG_VERIFY_EN.
module c_wl_prog_ctrl #(
    parameter int N_VPE = 5,
    parameter int N_ROW = 61,
    parameter int PW_W  = 4
`ifdef C_WL_PROG_VERIFY_EN
    ,
    parameter int MAX_RETRY = 3
`endif
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic            ABORT,
    input  logic [2:0]      VPE_FIRST,
    input  logic [2:0]      VPE_LAST,
    input  logic [PW_W-1:0] PULSE_LEN,
    input  logic            DIN_VALID,
    output logic            DIN_READY,
    output logic [2:0]      VPE_XIDX,
    output logic [5:0]      SW_IN_VPE,
    output logic            WL_EN,
    output logic            BUSY,
    output logic            DONE,
`ifdef C_WL_PROG_VERIFY_EN
    output logic            VFY_REQ,
    input  logic            VFY_ACK,
    input  logic            VFY_PASS,
`endif
    output logic            ERR
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        PULSE,
        HOLD,
        FIN
`ifdef C_WL_PROG_VERIFY_EN
        ,
        VERIFY
`endif
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [2:0]      last_q;
    logic [PW_W-1:0] plen_q;
    logic [PW_W-1:0] cnt;
    logic            range_ok;
    logic            start_ok;
    logic            start_bad;
    logic            step;
    logic            last_row;
    logic            final_row;
    logic            fail;

`ifdef C_WL_PROG_VERIFY_EN
    localparam int RW = $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry;
    logic          retry_up;
`endif

    // Next-state decode; ABORT overrides every transition out of a busy state.
    always_comb begin
        nxt       = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        step      = 1'b0;
        fail      = 1'b0;
`ifdef C_WL_PROG_VERIFY_EN
        retry_up  = 1'b0;
`endif
        range_ok  = (VPE_FIRST <= VPE_LAST) &&
                    (VPE_LAST <= 3'(N_VPE - 1));
        last_row  = (SW_IN_VPE == 6'(N_ROW - 1));
        final_row = last_row && (VPE_XIDX >= last_q);
        unique case (state)
            IDLE: begin
                if (START && !ABORT) begin
                    if (range_ok) begin
                        start_ok = 1'b1;
                        nxt      = FETCH;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            FETCH: if (DIN_VALID) nxt = SETUP;
            SETUP: nxt = PULSE;
            PULSE: if (cnt <= PW_W'(1)) nxt = HOLD;
`ifdef C_WL_PROG_VERIFY_EN
            HOLD: nxt = VERIFY;
            VERIFY: begin
                if (VFY_ACK) begin
                    if (VFY_PASS) begin
                        step = 1'b1;
                    end else if (retry == RW'(MAX_RETRY)) begin
                        fail = 1'b1;
                        nxt  = IDLE;
                    end else begin
                        retry_up = 1'b1;
                        nxt      = SETUP;
                    end
                end
            end
`else
            HOLD: step = 1'b1;
`endif
            FIN: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (step) nxt = final_row ? FIN : FETCH;
        if (ABORT && state != IDLE) begin
            nxt  = IDLE;
            step = 1'b0;
            fail = 1'b0;
`ifdef C_WL_PROG_VERIFY_EN
            retry_up = 1'b0;
`endif
        end
    end

    // State, registered outputs, address stepping and pulse counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            DIN_READY <= 1'b0;
            WL_EN     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            VPE_XIDX  <= 3'd0;
            SW_IN_VPE <= 6'd0;
            last_q    <= 3'd0;
            plen_q    <= PW_W'(1);
            cnt       <= '0;
`ifdef C_WL_PROG_VERIFY_EN
            VFY_REQ   <= 1'b0;
            retry     <= '0;
`endif
        end else begin
            state     <= nxt;
            DIN_READY <= (nxt == FETCH);
            WL_EN     <= (nxt == PULSE);
            BUSY      <= (nxt != IDLE);
            DONE      <= (state == FIN) && !ABORT;
            ERR       <= start_bad || fail;
            if (start_ok) begin
                VPE_XIDX  <= VPE_FIRST;
                SW_IN_VPE <= 6'd0;
                last_q    <= VPE_LAST;
                plen_q    <= (PULSE_LEN == '0) ? PW_W'(1) : PULSE_LEN;
            end else if (step && !final_row) begin
                if (last_row) begin
                    SW_IN_VPE <= 6'd0;
                    VPE_XIDX  <= VPE_XIDX + 3'd1;
                end else begin
                    SW_IN_VPE <= SW_IN_VPE + 6'd1;
                end
            end
            if (state == SETUP) cnt <= plen_q;
            else if (state == PULSE) cnt <= cnt - PW_W'(1);
`ifdef C_WL_PROG_VERIFY_EN
            VFY_REQ <= (nxt == VERIFY);
            if (start_ok || step) retry <= '0;
            else if (retry_up) retry <= retry + RW'(1);
`endif
        end
    end

endmodule

// File: tb/tb_c_wl_prog_ctrl.sv
// Scoreboard bench for c_wl_prog_ctrl: expected pulses/DONE/ERR are queued
// by the stimulus and consumed by an independent negedge monitor.
module tb_c_wl_prog_ctrl;
    logic       CLK = 0, RST_N = 0, START = 0, ABORT = 0, DIN_VALID = 0;
    logic [2:0] VPE_FIRST = 0, VPE_LAST = 0;
    logic [3:0] PULSE_LEN = 0;
    logic       DIN_READY, WL_EN, BUSY, DONE, ERR;
    logic [2:0] VPE_XIDX;
    logic [5:0] SW_IN_VPE;
`ifdef C_WL_PROG_VERIFY_EN
    localparam int EXTRA = 1;
    logic VFY_REQ, VFY_ACK, VFY_PASS;
    logic fail5 = 0;
    assign VFY_ACK  = VFY_REQ;
    assign VFY_PASS = !(fail5 && SW_IN_VPE == 6'd5);
`else
    localparam int EXTRA = 0;
`endif

    c_wl_prog_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
        .VPE_FIRST(VPE_FIRST), .VPE_LAST(VPE_LAST),
        .PULSE_LEN(PULSE_LEN), .DIN_VALID(DIN_VALID),
        .DIN_READY(DIN_READY), .VPE_XIDX(VPE_XIDX),
        .SW_IN_VPE(SW_IN_VPE), .WL_EN(WL_EN), .BUSY(BUSY),
        .DONE(DONE),
`ifdef C_WL_PROG_VERIFY_EN
        .VFY_REQ(VFY_REQ), .VFY_ACK(VFY_ACK), .VFY_PASS(VFY_PASS),
`endif
        .ERR(ERR)
    );

    typedef struct {int vpe; int sw; int w;} pulse_t;
    pulse_t pq[$];
    int     dq[$];
    int     eq[$];
    int     total = 0, bad = 0, cyc = 0;
    bit     chk_en = 1;

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: measures each WL_EN pulse and checks address stability.
    initial begin
        bit     pw = 0;
        int     pv = 0, ps = 0, pwid = 0, pa = 0, e;
        pulse_t x;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                pw = 0;
            end else begin
                if (chk_en && WL_EN)
                    chk("addr_stable", int'({VPE_XIDX, SW_IN_VPE}), pa);
                if (WL_EN && !pw) begin
                    pv = VPE_XIDX; ps = SW_IN_VPE; pwid = 1;
                end else if (WL_EN) begin
                    pwid++;
                end
                if (!WL_EN && pw && chk_en) begin
                    if (pq.size() == 0) begin
                        chk("pulse_expected", 0, 1);
                    end else begin
                        x = pq.pop_front();
                        chk("pulse_vpe", pv, x.vpe);
                        chk("pulse_row", ps, x.sw);
                        chk("pulse_width", pwid, x.w);
                    end
                end
                pw = WL_EN;
                if (DONE) begin
                    if (dq.size() == 0) chk("done_expected", 0, 1);
                    else begin
                        e = dq.pop_front();
                        if (e >= 0) chk("done_cycle", cyc, e);
                    end
                end
                if (ERR) begin
                    if (eq.size() == 0) chk("err_expected", 0, 1);
                    else begin
                        e = eq.pop_front();
                        if (e >= 0) chk("err_cycle", cyc, e);
                    end
                end
            end
            pa = int'({VPE_XIDX, SW_IN_VPE});
        end
    end

    task automatic push_rows(int f, int l, int pe);
        for (int v = f; v <= l; v++)
            for (int s = 0; s < 61; s++)
                pq.push_back('{v, s, pe});
    endtask

    task automatic run(int f, int l, int p, bit rv);
        int pe, r, k;
        pe = (p == 0) ? 1 : p;
        r  = (l - f + 1) * 61;
        push_rows(f, l, pe);
        @(posedge CLK); #1;
        VPE_FIRST = 3'(f); VPE_LAST = 3'(l); PULSE_LEN = 4'(p);
        START = 1; DIN_VALID = 1;
        dq.push_back(rv ? -1 : cyc + 2 + r * (pe + 3 + EXTRA));
        @(posedge CLK); #1;
        START = 0;
        for (k = 0; k < 20000 && (BUSY || dq.size() != 0); k++) begin
            if (rv) DIN_VALID = ($urandom_range(3) != 0);
            @(posedge CLK); #1;
        end
        DIN_VALID = 0;
        chk("run_done_pending", dq.size(), 0);
        chk("run_rows_left", pq.size(), 0);
    endtask

    task automatic bad_start(int f, int l);
        @(posedge CLK); #1;
        VPE_FIRST = 3'(f); VPE_LAST = 3'(l); START = 1;
        eq.push_back(cyc + 1);
        @(posedge CLK); #1;
        START = 0;
        repeat (3) begin
            chk("bad_start_busy", BUSY, 0);
            @(posedge CLK); #1;
        end
        chk("bad_start_err_pending", eq.size(), 0);
    endtask

    initial begin
        int k, p;
        #2;
        chk("reset_outputs", int'({DIN_READY, WL_EN, BUSY, DONE, ERR,
                                   VPE_XIDX, SW_IN_VPE}), 0);
        #10 RST_N = 1;

        run(2, 2, 2, 0);
        run(0, 4, 0, 0);
        bad_start(3, 1);
        bad_start(0, 5);

        // START together with ABORT in IDLE is ignored.
        @(posedge CLK); #1;
        VPE_FIRST = 0; VPE_LAST = 1; START = 1; ABORT = 1;
        @(posedge CLK); #1;
        START = 0; ABORT = 0;
        chk("start_abort_busy", BUSY, 0);

        // Stall FETCH at row 1/30, then abort.
        p = $urandom_range(4, 1);
        push_rows(0, 0, p);
        for (int s = 0; s < 30; s++) pq.push_back('{1, s, p});
        @(posedge CLK); #1;
        VPE_FIRST = 0; VPE_LAST = 4; PULSE_LEN = 4'(p);
        START = 1; DIN_VALID = 1;
        @(posedge CLK); #1;
        START = 0;
        for (k = 0; k < 5000 &&
             !(WL_EN && VPE_XIDX == 1 && SW_IN_VPE == 29); k++)
            @(posedge CLK); #1;
        chk("reach_row_29", int'(k < 5000), 1);
        DIN_VALID = 0;
        for (k = 0; k < 50 && !DIN_READY; k++) @(posedge CLK); #1;
        chk("stall_addr", int'({VPE_XIDX, SW_IN_VPE}), int'({3'd1, 6'd30}));
        repeat (10) begin
            @(posedge CLK); #1;
            chk("stall_ready", DIN_READY, 1);
        end
        ABORT = 1;
        @(posedge CLK); #1;
        ABORT = 0;
        chk("abort_outputs", int'({BUSY, WL_EN, DIN_READY}), 0);
        repeat (5) @(posedge CLK); #1;
        chk("abort_rows_left", pq.size(), 0);
        run(4, 4, 1, 0);

        // Reset while WL_EN is high.
        chk_en = 0;
        @(posedge CLK); #1;
        VPE_FIRST = 0; VPE_LAST = 0; PULSE_LEN = 8;
        START = 1; DIN_VALID = 1;
        @(posedge CLK); #1;
        START = 0;
        for (k = 0; k < 50 && !WL_EN; k++) @(posedge CLK); #1;
        chk("reset_test_pulse", WL_EN, 1);
        #2 RST_N = 0;
        #1 chk("async_reset_outputs",
               int'({DIN_READY, WL_EN, BUSY, DONE, ERR,
                     VPE_XIDX, SW_IN_VPE}), 0);
        DIN_VALID = 0;
        @(posedge CLK); #1;
        RST_N = 1;
        @(posedge CLK); #1;
        chk("after_reset_busy", BUSY, 0);
        chk_en = 1;

`ifdef C_WL_PROG_VERIFY_EN
        fail5 = 1;
        for (int s = 0; s < 5; s++) pq.push_back('{0, s, 1});
        repeat (4) pq.push_back('{0, 5, 1});
        eq.push_back(-1);
        @(posedge CLK); #1;
        VPE_FIRST = 0; VPE_LAST = 0; PULSE_LEN = 1;
        START = 1; DIN_VALID = 1;
        @(posedge CLK); #1;
        START = 0;
        for (k = 0; k < 500 && (BUSY || eq.size() != 0); k++)
            @(posedge CLK); #1;
        chk("verify_err_pending", eq.size(), 0);
        chk("verify_rows_left", pq.size(), 0);
        fail5 = 0;
        DIN_VALID = 0;
`endif

        repeat (3) begin
            int f, l;
            f = $urandom_range(4);
            l = $urandom_range(4, f);
            run(f, l, $urandom_range(15), 1);
        end

        repeat (5) @(posedge CLK); #1;
        chk("final_pulse_q", pq.size(), 0);
        chk("final_done_q", dq.size(), 0);
        chk("final_err_q", eq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/c_wl_prog_ctrl.md
Name: c_wl_prog_ctrl

Overview:
- Sequencer that steps the crossbar wordline decoder through every row of a selected range of VPEs. Each VPE has 61 rows: rows 0..59 are switch rows and row 60 is the sign row.
- For each row it fetches the row data via a valid/ready handshake, drives a stable address (VPE_XIDX, SW_IN_VPE), then asserts the write-enable gate WL_EN for a programmable pulse width.
- It sits between the weight-load host interface and the wordline decoder / bitline drivers.

Parameters:
- N_VPE, 5, number of VPEs; legal VPE_XIDX values are 0..N_VPE-1.
- N_ROW, 61, rows per VPE; the last row (N_ROW-1) is the sign row.
- PW_W, 4, width of the pulse-length field and pulse counter.
- MAX_RETRY, 3, verify retries per row (used only with the optional feature).

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  begins a programming run; sampled only in IDLE.
- ABORT  in  1  terminates any run.
- VPE_FIRST  in  3  first VPE of the range, inclusive; latched on START.
- VPE_LAST  in  3  last VPE of the range, inclusive; latched on START.
- PULSE_LEN  in  PW_W  WL_EN high time in cycles; latched on START; 0 is treated as 1.
- DIN_VALID  in  1  row data available.
- DIN_READY  out  1  controller accepts row data.
- VPE_XIDX  out  3  decoder VPE select.
- SW_IN_VPE  out  6  decoder row select.
- WL_EN  out  1  wordline write gate.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when a run completes.
- ERR  out  1  one-cycle pulse when a START is rejected (or, with the optional feature, when verify fails).

Behaviour:
- All outputs are registered.
- Reset values: VPE_XIDX=0, SW_IN_VPE=0, WL_EN=0, DIN_READY=0, BUSY=0, DONE=0, ERR=0; state=IDLE.
- States: IDLE, FETCH, SETUP, PULSE, HOLD, FIN.
- IDLE:
  - START with VPE_FIRST<=VPE_LAST and VPE_LAST<=N_VPE-1: latch the range and pulse length; load VPE_XIDX=VPE_FIRST, SW_IN_VPE=0; go to FETCH.
  - START with an illegal range: ERR=1 for one cycle; stay in IDLE.
- FETCH: DIN_READY=1. When DIN_VALID=1, the handshake completes in that cycle; go to SETUP. DIN_READY is low in every other state.
- SETUP: one cycle, address stable, WL_EN=0. Load the pulse counter; go to PULSE.
- PULSE: WL_EN=1 for exactly max(PULSE_LEN,1) cycles; the address is held stable throughout; then go to HOLD.
- HOLD: one cycle, WL_EN=0, address unchanged. On exit the address advances:
  - If SW_IN_VPE<N_ROW-1: SW_IN_VPE+1, go to FETCH.
  - Else, if VPE_XIDX<latched last: SW_IN_VPE wraps to 0, VPE_XIDX+1, go to FETCH.
  - Else: go to FIN.
- FIN: DONE=1 for one cycle; go to IDLE. Address outputs keep their final values until the next START.
- Timing: with DIN_VALID held high, each row takes P+3 cycles (P = effective pulse length). FETCH is entered on the cycle after START is sampled. DONE asserts 1 + R*(P+3) cycles after that sample, where R is the total number of rows in the range.
- WL_EN never goes high in the same cycle as an address change. The address changes only on the HOLD→FETCH transition or on START.
- ABORT has priority over all other transitions. From any non-IDLE state it forces the next state to IDLE with WL_EN=0 and DIN_READY=0, and DONE is not pulsed. ABORT and START together in IDLE: START is ignored.
- START while BUSY is ignored.
- Asserting RST_N low mid-run immediately clears all state and outputs to their reset values.

Optional Feature:
- Macro: C_WL_PROG_VERIFY_EN.
- Defined:
  - Adds ports VFY_REQ (out, 1), VFY_ACK (in, 1) and VFY_PASS (in, 1), plus a VERIFY state after HOLD.
  - In VERIFY, VFY_REQ=1 until VFY_ACK=1, and the address is held.
  - VFY_PASS=1 at ack: advance the address as for HOLD.
  - VFY_PASS=0 at ack: return to SETUP for the same row (no new fetch); increment the per-row retry count, which resets on each advance.
  - A failure once MAX_RETRY retries have been used: ERR=1 for one cycle, go to IDLE, no DONE.
- Undefined: the VFY_* ports and the VERIFY state do not exist; HOLD advances directly.

Test Plan:
- Reset mid-PULSE (RST_N low while WL_EN=1) -> all outputs 0 in the same cycle; BUSY=0; state is IDLE after release.
- START with FIRST=LAST=2, PULSE_LEN=2, DIN_VALID=1 -> 61 rows visited with SW_IN_VPE 0..60 and VPE_XIDX=2; WL_EN high for 122 cycles total; DONE asserts exactly 306 cycles after the START sample.
- START with FIRST=0, LAST=4, PULSE_LEN=0 -> 305 rows in order; SW_IN_VPE wraps 60→0 while VPE_XIDX increments 0→4; WL_EN pulses are 1 cycle wide; DONE after 1+305*4 = 1221 cycles.
- START with FIRST=3, LAST=1, then FIRST=0, LAST=5 -> ERR pulses once per START; BUSY stays 0; no WL_EN activity.
- DIN_VALID held low for 10 cycles in FETCH, then ABORT asserted at VPE_XIDX=1, SW_IN_VPE=30 -> DIN_READY stays high while waiting; after ABORT, IDLE on the next cycle with WL_EN=0 and no DONE; a subsequent START is accepted.
- With C_WL_PROG_VERIFY_EN, MAX_RETRY=3, VFY_PASS=0 on row 5 -> exactly 4 pulses are issued on row 5, then ERR=1 and return to IDLE.
